ahb_wait_slave: RTL and testbench

// - AHB-Lite slave responder with a byte-enabled local SRAM and programmable wait states.
// - Sits on the pad side of the BIU, behind the master-side delay FIFO, as the memory

---
 rtl/ahb_wait_slave_pkg.sv | 47 ++++
 rtl/ahb_wait_slave_if.sv | 34 +++
 rtl/ahb_wait_slave_mem.sv | 37 +++
 rtl/ahb_wait_slave.sv | 165 ++++++++++++++++
 tb/tb_ahb_wait_slave.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_wait_slave_pkg.sv
// Shared definitions for the AHB wait-state slave.
// Purpose: AHB-Lite transfer, size and response codes, the responder FSM
//          state encoding, and helpers that turn a transfer's size and low
//          address bits into a byte-lane mask.
// Ports:   none (package).
package ahb_wait_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Byte lanes touched by a transfer; unsupported sizes touch nothing.
  function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr_lo;
      HSIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: m = 4'b1111;
      default:    m = 4'b0000;
    endcase
    return m;
  endfunction

  // Expand a 4-bit lane mask to a 32-bit data mask.
  function automatic logic [31:0] bytes_to_bits(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/ahb_wait_slave_if.sv
// AHB-Lite bus bundle between one master and the wait-state slave.
// Purpose: groups address-phase, data-phase and response signals.
// Ports (signals):
//   hsel, haddr[31:0], htrans[1:0], hwrite, hsize[2:0], hburst[1:0],
//   hprot[3:0], hwdata[31:0], hready_in   : master -> slave
//   hready_out, hresp, hrdata[31:0]        : slave -> master
// Handshake: an address phase is taken when hsel & htrans[1] & hready_in are
// high at a rising edge; its data phase then lasts until a rising edge with
// hready_out high, and hresp/hrdata are only meaningful in that final cycle
// (hresp is also high during the first, stalled cycle of an ERROR pair).
interface ahb_wait_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready_in,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready_in,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/ahb_wait_slave_mem.sv
// Local SRAM for the AHB wait-state slave.
// Purpose: 2^AW x 32-bit array, combinational read, synchronous byte-enabled
//          write. Contents are not reset. Isolated so a memory macro with the
//          same port shape can replace it.
// Ports:
//   cpu_clk       clock for the write port
//   rd_addr[AW]   read word index
//   rd_data[32]   read data (combinational)
//   wr_en         write strobe
//   wr_addr[AW]   write word index
//   wr_be[4]      byte enables
//   wr_data[32]   write data
module ahb_wait_slave_mem #(
  parameter int AW = 10
) (
  input  logic          cpu_clk,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [0:(1<<AW)-1];

  assign rd_data = mem[rd_addr];

  always_ff @(posedge cpu_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/ahb_wait_slave.sv
// AHB-Lite slave responder with byte-enabled local SRAM and programmable
// wait states.
// Purpose: memory target that stretches data phases with hready_out and
//          returns a two-cycle ERROR for out-of-window, misaligned or
//          unsupported-size accesses.
// Ports:
//   cpu_clk          clock
//   cpu_rst_b        asynchronous active-low reset
//   wait_nseq[3:0]   wait states for NONSEQ beats (sampled at accept)
//   wait_seq[3:0]    wait states for SEQ beats (sampled at accept)
//   bus              AHB-Lite slave modport (see ahb_wait_slave_if)
//   dbg_state        current responder state
module ahb_wait_slave
  import ahb_wait_slave_pkg::*;
#(
  parameter int          MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst_b,
  input  logic [3:0]            wait_nseq,
  input  logic [3:0]            wait_seq,
  ahb_wait_slave_if.slave       bus,
  output state_t                dbg_state
);

  state_t            state;
  logic              hready_q;
  logic              hresp_q;
  logic [3:0]        wait_cnt;
  logic              hwrite_q;
  logic [3:0]        be_q;
  logic [MEM_AW-1:0] word_q;
  logic              err_q;

  logic [31:0]       offset;
  logic              can_accept;
  logic              accept;
  logic              range_err;
  logic              size_err;
  logic              align_err;
  logic              addr_err;
  logic [3:0]        wait_sel;
  logic [3:0]        lanes;

  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       hrdata_c;

  // Wraps for haddr below the base, which then lands far out of range.
  assign offset = bus.haddr - BASE_ADDR;

  // Only states that drive hready_out high end a data phase, so only they
  // may take the next address phase.
  assign can_accept = (state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2);
  assign accept     = bus.hsel & bus.htrans[1] & bus.hready_in & can_accept;

  assign range_err = |offset[31:MEM_AW+2];
  assign size_err  = bus.hsize > HSIZE_WORD;
  assign align_err = ((bus.hsize == HSIZE_HALF) && bus.haddr[0]) ||
                     ((bus.hsize == HSIZE_WORD) && (bus.haddr[1:0] != 2'b00));
  assign addr_err  = range_err | size_err | align_err;

  assign wait_sel = bus.htrans[0] ? wait_seq : wait_nseq;
  assign lanes    = lane_mask(bus.hsize, bus.haddr[1:0]);

  // Bus attributes that carry no meaning for a flat SRAM target.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.hburst, bus.hprot, offset[1:0]};

  always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
    if (!cpu_rst_b) begin
      state    <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      wait_cnt <= 4'd0;
      hwrite_q <= 1'b0;
      be_q     <= 4'b0000;
      word_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        hwrite_q <= bus.hwrite;
        be_q     <= lanes;
        word_q   <= offset[MEM_AW+1:2];
        err_q    <= addr_err;
      end

      case (state)
        ST_IDLE, ST_LAST, ST_ERR2: begin
          if (accept) begin
            if (addr_err) begin
              state    <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= HRESP_ERROR;
              wait_cnt <= 4'd0;
            end else if (wait_sel == 4'd0) begin
              state    <= ST_LAST;
              hready_q <= 1'b1;
              hresp_q  <= HRESP_OKAY;
              wait_cnt <= 4'd0;
            end else begin
              state    <= ST_WAIT;
              hready_q <= 1'b0;
              hresp_q  <= HRESP_OKAY;
              wait_cnt <= wait_sel;
            end
          end else begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
          end
        end
        ST_WAIT: begin
          // Count N..1 while stalled, giving exactly N low cycles.
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state    <= ST_LAST;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: begin
          state    <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Write lands at the edge closing LAST, so a pipelined read of the same
  // word sees it in its own LAST cycle.
  assign mem_we = (state == ST_LAST) && hwrite_q && !err_q;

  ahb_wait_slave_mem #(
    .AW(MEM_AW)
  ) u_mem (
    .cpu_clk (cpu_clk),
    .rd_addr (word_q),
    .rd_data (mem_rdata),
    .wr_en   (mem_we),
    .wr_addr (word_q),
    .wr_be   (be_q),
    .wr_data (bus.hwdata)
  );

  always_comb begin
    hrdata_c = '0;
    if ((state == ST_LAST) && !hwrite_q) begin
      hrdata_c = mem_rdata & bytes_to_bits(be_q);
    end
  end

  assign bus.hready_out = hready_q;
  assign bus.hresp      = hresp_q;
  assign bus.hrdata     = hrdata_c;
  assign dbg_state      = state;

endmodule

// File: tb/tb_ahb_wait_slave.sv
// Bench for ahb_wait_slave: directed vector table, hand-written multi-cycle
// sequences (burst waits, pipelined hazard, mid-beat wait change, reset in
// WAIT) and random bursts checked against a byte-level memory model.
module tb_ahb_wait_slave;
  import ahb_wait_slave_pkg::*;

  localparam logic [31:0] BASE = 32'h6000_0000;

  logic       cpu_clk;
  logic       cpu_rst_b;
  logic [3:0] wait_nseq;
  logic [3:0] wait_seq;
  state_t     dbg_state;

  ahb_wait_slave_if bus ();

  ahb_wait_slave #(
    .MEM_AW    (10),
    .BASE_ADDR (BASE)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst_b (cpu_rst_b),
    .wait_nseq (wait_nseq),
    .wait_seq  (wait_seq),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Single-slave bus: the bus-level ready is the slave's own ready.
  assign bus.hready_in = bus.hready_out;

  // ---------------- clock / reset ----------------
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:1023];

  function automatic logic model_err(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] off;
    off = addr - BASE;
    if (off >= 32'h1000) return 1'b1;
    if (size > 3'd2) return 1'b1;
    if (size == 3'd1 && addr[0]) return 1'b1;
    if (size == 3'd2 && addr[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // Bytes covered: from addr[1:0] for 2^size bytes.
  function automatic logic [31:0] model_bits(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] m;
    int lo, n;
    m  = '0;
    lo = int'(addr[1:0]);
    n  = 1 << size;
    for (int b = 0; b < 4; b++) begin
      if (b >= lo && b < lo + n) m[8*b +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // ---------------- driver / engine ----------------
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
  } beat_t;

  beat_t       beats   [16];
  int          nbeats;
  int          r_waits [16];
  int          r_bad   [16];
  logic        r_err   [16];
  logic [31:0] r_rdata [16];
  int          e_waits [16];
  logic        e_err   [16];
  logic [31:0] e_rdata [16];
  int          run_cycles;
  bit          perturb;

  task automatic drive_idle();
    bus.hsel   = 1'b0;
    bus.htrans = HTRANS_IDLE;
    bus.haddr  = '0;
    bus.hwrite = 1'b0;
    bus.hsize  = HSIZE_WORD;
    bus.hburst = 2'b00;
    bus.hprot  = 4'b0011;
  endtask

  task automatic model_complete(input int d);
    logic [31:0] m;
    int idx;
    e_rdata[d] = '0;
    if (!e_err[d]) begin
      m   = model_bits(beats[d].addr, beats[d].size);
      idx = int'((beats[d].addr - BASE) >> 2);
      if (beats[d].write) ref_mem[idx] = (ref_mem[idx] & ~m) | (beats[d].wdata & m);
      else                e_rdata[d]   = ref_mem[idx] & m;
    end
  endtask

  // Pipelined master: beat a is in its address phase while beat d is in
  // its data phase; both advance on an edge where hready_out is high.
  task automatic run_beats();
    int a, d, cyc;
    a = 0; d = -1; cyc = 0;
    for (int i = 0; i < 16; i++) begin
      r_waits[i] = 0; r_bad[i] = 0; r_err[i] = 1'bx; r_rdata[i] = 'x;
    end
    while ((a < nbeats || d >= 0) && cyc < 300) begin
      @(negedge cpu_clk);
      cyc++;
      if (a < nbeats) begin
        bus.hsel   = 1'b1;
        bus.haddr  = beats[a].addr;
        bus.htrans = beats[a].trans;
        bus.hwrite = beats[a].write;
        bus.hsize  = beats[a].size;
        bus.hburst = 2'b01;
      end else begin
        drive_idle();
      end
      bus.hwdata = (d >= 0) ? beats[d].wdata : $urandom;
      if (perturb && d >= 0) begin
        wait_nseq = 4'($urandom_range(0, 6));
        wait_seq  = 4'($urandom_range(0, 3));
      end
      #1;
      if (d >= 0) begin
        if (bus.hready_out) begin
          r_err[d]   = bus.hresp;
          r_rdata[d] = bus.hrdata;
          model_complete(d);
        end else begin
          r_waits[d]++;
          if (bus.hresp !== e_err[d] || bus.hrdata !== 32'h0) r_bad[d]++;
        end
      end
      if (bus.hready_out) begin
        if (a < nbeats) begin
          e_err[a]   = model_err(beats[a].addr, beats[a].size);
          e_waits[a] = e_err[a] ? 1 :
                       (beats[a].trans == HTRANS_SEQ ? int'(wait_seq) : int'(wait_nseq));
          d = a;
          a++;
        end else begin
          d = -1;
        end
      end
    end
    run_cycles = cyc;
    if (cyc >= 300) begin
      checks++;
      errors++;
      $display("FAIL engine_timeout actual=%0d cycles expected=<300", cyc);
    end
  endtask

  task automatic check_beat(input string tag, input int i);
    chk({tag, "_resp"},  32'(r_err[i]), 32'(e_err[i]));
    chk({tag, "_waits"}, r_waits[i], e_waits[i]);
    chk({tag, "_rdata"}, r_rdata[i], e_rdata[i]);
    chk({tag, "_stall"}, r_bad[i], 0);
  endtask

  function automatic beat_t mk(input logic [31:0] addr, input logic wr,
                               input logic [2:0] size, input logic [1:0] trans,
                               input logic [31:0] wdata);
    beat_t b;
    b.addr = addr; b.write = wr; b.size = size; b.trans = trans; b.wdata = wdata;
    return b;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wn;
    logic        exp_err;
    int          exp_waits;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [23];

  initial begin
    cpu_rst_b = 1'b0;
    wait_nseq = 4'd0;
    wait_seq  = 4'd0;
    perturb   = 1'b0;
    bus.hwdata = '0;
    drive_idle();
    repeat (3) @(negedge cpu_clk);
    #1;
    chk("rst_hready", 32'(bus.hready_out), 32'h1);
    chk("rst_hresp",  32'(bus.hresp), 32'h0);
    chk("rst_hrdata", bus.hrdata, 32'h0);
    chk("rst_state",  32'(dbg_state), 32'(ST_IDLE));
    @(negedge cpu_clk);
    cpu_rst_b = 1'b1;

    vecs[0]  = '{32'h6000_0010, 1, 3'd2, 32'hDEAD_BEEF, 4'd0, 0, 0, 32'h0};
    vecs[1]  = '{32'h6000_0010, 0, 3'd2, 32'h0,        4'd0, 0, 0, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h6000_0010, 0, 3'd2, 32'h0,        4'd3, 0, 3, 32'hDEAD_BEEF};
    vecs[3]  = '{32'h6000_0013, 1, 3'd0, 32'hAA00_0000, 4'd0, 0, 0, 32'h0};
    vecs[4]  = '{32'h6000_0010, 0, 3'd2, 32'h0,        4'd0, 0, 0, 32'hAAAD_BEEF};
    vecs[5]  = '{32'h6000_0011, 0, 3'd0, 32'h0,        4'd0, 0, 0, 32'h0000_BE00};
    vecs[6]  = '{32'h6000_0012, 0, 3'd1, 32'h0,        4'd0, 0, 0, 32'hAAAD_0000};
    vecs[7]  = '{32'h6000_1000, 0, 3'd2, 32'h0,        4'd0, 1, 1, 32'h0};
    vecs[8]  = '{32'h6000_0002, 0, 3'd2, 32'h0,        4'd0, 1, 1, 32'h0};
    vecs[9]  = '{32'h6000_0012, 1, 3'd2, 32'h1111_1111, 4'd0, 1, 1, 32'h0};
    vecs[10] = '{32'h6000_0010, 0, 3'd2, 32'h0,        4'd0, 0, 0, 32'hAAAD_BEEF};
    vecs[11] = '{32'h6000_0011, 0, 3'd1, 32'h0,        4'd0, 1, 1, 32'h0};
    vecs[12] = '{32'h6000_0010, 0, 3'd3, 32'h0,        4'd0, 1, 1, 32'h0};
    vecs[13] = '{32'h5FFF_FFFC, 0, 3'd2, 32'h0,        4'd0, 1, 1, 32'h0};
    vecs[14] = '{32'h6000_0FFC, 1, 3'd2, 32'h1234_5678, 4'd2, 0, 2, 32'h0};
    vecs[15] = '{32'h6000_0FFC, 0, 3'd2, 32'h0,        4'd1, 0, 1, 32'h1234_5678};
    vecs[16] = '{32'h6000_0FFF, 0, 3'd0, 32'h0,        4'd0, 0, 0, 32'h1200_0000};
    vecs[17] = '{32'h6000_0014, 1, 3'd2, 32'h7654_3210, 4'd0, 0, 0, 32'h0};
    vecs[18] = '{32'h6000_0016, 1, 3'd1, 32'hCAFE_1234, 4'd1, 0, 1, 32'h0};
    vecs[19] = '{32'h6000_0014, 0, 3'd2, 32'h0,        4'd0, 0, 0, 32'hCAFE_3210};
    vecs[20] = '{32'h6000_0015, 1, 3'd0, 32'hFFFF_A5FF, 4'd0, 0, 0, 32'h0};
    vecs[21] = '{32'h6000_0014, 0, 3'd2, 32'h0,        4'd15, 0, 15, 32'hCAFE_A510};
    vecs[22] = '{32'h6000_0010, 0, 3'd4, 32'h0,        4'd0, 1, 1, 32'h0};

    for (int v = 0; v < 23; v++) begin
      wait_nseq = vecs[v].wn;
      wait_seq  = 4'd0;
      nbeats    = 1;
      beats[0]  = mk(vecs[v].addr, vecs[v].write, vecs[v].size, HTRANS_NONSEQ, vecs[v].wdata);
      run_beats();
      chk($sformatf("vec%0d_resp", v),  32'(r_err[0]), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_waits", v), r_waits[0], vecs[v].exp_waits);
      chk($sformatf("vec%0d_rdata", v), r_rdata[0], vecs[v].exp_rdata);
      chk($sformatf("vec%0d_stall", v), r_bad[0], 0);
    end

    // INCR4 write then read: NONSEQ waits 2, each SEQ beat waits 1.
    wait_nseq = 4'd2;
    wait_seq  = 4'd1;
    nbeats    = 4;
    for (int i = 0; i < 4; i++)
      beats[i] = mk(32'h6000_0040 + 32'(4*i), 1'b1, HSIZE_WORD,
                    (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'hA000_0000 + 32'(i));
    run_beats();
    for (int i = 0; i < 4; i++) chk($sformatf("incr4_wr%0d_waits", i), r_waits[i], (i == 0) ? 2 : 1);
    for (int i = 0; i < 4; i++) beats[i].write = 1'b0;
    run_beats();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr4_rd%0d_waits", i), r_waits[i], (i == 0) ? 2 : 1);
      chk($sformatf("incr4_rd%0d_data", i), r_rdata[i], 32'hA000_0000 + 32'(i));
      check_beat($sformatf("incr4_rd%0d", i), i);
    end

    // Pipelined write then read of the same word, no waits, no bubble.
    wait_nseq = 4'd0;
    wait_seq  = 4'd0;
    nbeats    = 2;
    beats[0]  = mk(32'h6000_0020, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h5EED_1234);
    beats[1]  = mk(32'h6000_0020, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
    run_beats();
    chk("b2b_rdata", r_rdata[1], 32'h5EED_1234);
    chk("b2b_waits", r_waits[0] + r_waits[1], 0);
    chk("b2b_cycles", run_cycles, 3);

    // Wait configuration changing during a beat's stall has no effect on it.
    wait_nseq = 4'd4;
    perturb   = 1'b1;
    nbeats    = 1;
    beats[0]  = mk(32'h6000_0010, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
    run_beats();
    perturb   = 1'b0;
    chk("midbeat_waits", r_waits[0], 4);
    chk("midbeat_rdata", r_rdata[0], 32'hAAAD_BEEF);

    // Reset asserted in WAIT of a write: outputs recover at once, word kept.
    wait_nseq = 4'd0;
    nbeats    = 1;
    beats[0]  = mk(32'h6000_0030, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h0102_0304);
    run_beats();
    wait_nseq = 4'd5;
    @(negedge cpu_clk);
    bus.hsel = 1'b1; bus.haddr = 32'h6000_0030; bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = 1'b1; bus.hsize = HSIZE_WORD;
    @(negedge cpu_clk);
    drive_idle();
    bus.hwdata = 32'h9999_9999;
    #1;
    chk("rstmid_inwait", 32'(bus.hready_out), 32'h0);
    @(negedge cpu_clk);
    #1;
    cpu_rst_b = 1'b0;
    #1;
    chk("rstmid_hready", 32'(bus.hready_out), 32'h1);
    chk("rstmid_hresp",  32'(bus.hresp), 32'h0);
    chk("rstmid_state",  32'(dbg_state), 32'(ST_IDLE));
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst_b = 1'b1;
    wait_nseq = 4'd0;
    beats[0]  = mk(32'h6000_0030, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
    run_beats();
    chk("rstmid_word", r_rdata[0], 32'h0102_0304);

    // Random phase: prefill the first 64 words, then mixed bursts.
    perturb = 1'b1;
    for (int blk = 0; blk < 8; blk++) begin
      nbeats = 8;
      for (int i = 0; i < 8; i++)
        beats[i] = mk(BASE + 32'(32*blk + 4*i), 1'b1, HSIZE_WORD,
                      (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, $urandom);
      run_beats();
      for (int i = 0; i < 8; i++) check_beat($sformatf("fill%0d_%0d", blk, i), i);
    end
    for (int t = 0; t < 40; t++) begin
      nbeats = $urandom_range(1, 8);
      for (int i = 0; i < nbeats; i++) begin
        logic [31:0] off;
        logic [2:0]  sz;
        int r;
        r  = $urandom_range(0, 15);
        sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        if (r == 0)      off = 32'h1000 + 32'($urandom_range(0, 255) * 4);
        else if (r == 1) off = 32'h0 - 32'($urandom_range(1, 16));
        else begin
          off = 32'($urandom_range(0, 63) * 4);
          if ($urandom_range(0, 3) == 0) off[1:0] = 2'($urandom_range(0, 3));
          else if (sz == 3'd0)           off[1:0] = 2'($urandom_range(0, 3));
          else if (sz == 3'd1)           off[1]   = 1'($urandom_range(0, 1));
        end
        beats[i] = mk(BASE + off, 1'($urandom_range(0, 1)), sz,
                      (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, $urandom);
      end
      run_beats();
      for (int i = 0; i < nbeats; i++) check_beat($sformatf("rnd%0d_%0d", t, i), i);
    end
    perturb = 1'b0;

    repeat (2) @(negedge cpu_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
